// File: rtl/pwm_inc_dec_gen.sv
// rtl/pwm_inc_dec_gen.sv - tick-driven PWM generator with saturating inc/dec duty steps
//
// Ports:
//   CLK          system clock
//   RST          synchronous active-high reset
//   enable_tick  single-cycle strobe that advances the period counter by one
//   inc          synchronized level; its rising edge raises duty by STEP
//   dec          synchronized level; its rising edge lowers duty by STEP
//   pwm_out      registered PWM output, high while cnt < duty_active
//   duty         requested duty (ticks high per period)
//   period_start one-CLK pulse when the counter wraps to 0
module pwm_inc_dec_gen #(
    parameter int WIDTH     = 8,
    parameter int PERIOD    = 100,
    parameter int STEP      = 10,
    parameter int DUTY_INIT = 50
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable_tick,
    input  logic             inc,
    input  logic             dec,
    output logic             pwm_out,
    output logic [WIDTH-1:0] duty,
    output logic             period_start
);

    localparam logic [WIDTH:0]   PERIOD_X = (WIDTH+1)'(PERIOD);
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(DUTY_INIT);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_req;
    logic [WIDTH-1:0] duty_active;
    logic             inc_d;
    logic             dec_d;
    logic             inc_rise;
    logic             dec_rise;
    logic [WIDTH:0]   req_x;
    logic [WIDTH:0]   up_x;
    logic [WIDTH:0]   dn_x;
    logic [WIDTH-1:0] duty_next;

    assign inc_rise = inc & ~inc_d;
    assign dec_rise = dec & ~dec_d;

    // One extra bit of headroom so the step can be compared against the
    // limits before it is truncated back to WIDTH.
    always_comb begin
        req_x     = {1'b0, duty_req};
        up_x      = req_x + STEP_X;
        dn_x      = req_x - STEP_X;
        duty_next = duty_req;
        if (inc_rise && !dec_rise) begin
            duty_next = (up_x > PERIOD_X) ? PERIOD_X[WIDTH-1:0] : up_x[WIDTH-1:0];
        end else if (dec_rise && !inc_rise) begin
            duty_next = (req_x < STEP_X) ? '0 : dn_x[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt          <= '0;
            duty_req     <= DUTY_RST;
            duty_active  <= DUTY_RST;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            inc_d        <= 1'b0;
            dec_d        <= 1'b0;
        end else begin
            inc_d    <= inc;
            dec_d    <= dec;
            duty_req <= duty_next;
            pwm_out  <= (cnt < duty_active);
            if (enable_tick) begin
                if (cnt == CNT_LAST) begin
                    cnt          <= '0;
                    // Old duty_req: a request landing on the wrap edge waits a period.
                    duty_active  <= duty_req;
                    period_start <= 1'b1;
                end else begin
                    cnt          <= cnt + 1'b1;
                    period_start <= 1'b0;
                end
            end else begin
                period_start <= 1'b0;
            end
        end
    end

    assign duty = duty_req;

endmodule

// File: tb/tb_pwm_inc_dec_gen.sv
// tb/tb_pwm_inc_dec_gen.sv - self-checking bench for pwm_inc_dec_gen
module tb_pwm_inc_dec_gen;

    localparam int P  = 100;
    localparam int S  = 10;
    localparam int DI = 50;

    typedef struct packed {
        logic       pwm;
        logic [7:0] duty;
        logic       ps;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       enable_tick = 1'b0;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       pwm_out;
    logic [7:0] duty;
    logic       period_start;

    int total = 0;
    int bad   = 0;

    exp_t sb_q[$];

    int m_cnt = 0, m_req = DI, m_act = DI;
    bit m_pwm = 0, m_ps = 0, m_incd = 0, m_decd = 0;

    pwm_inc_dec_gen #(.WIDTH(8), .PERIOD(P), .STEP(S), .DUTY_INIT(DI)) dut (
        .CLK(CLK), .RST(RST), .enable_tick(enable_tick), .inc(inc), .dec(dec),
        .pwm_out(pwm_out), .duty(duty), .period_start(period_start)
    );

    always #5 CLK = ~CLK;

    // Drives one CLK of stimulus, pushes the expected post-edge outputs and
    // pops them once the DUT has produced its registered outputs.
    task automatic drive_cycle(input bit r, input bit t, input bit i, input bit d, output exp_t e);
        int  nreq;
        bit  ir, dr;
        RST = r; enable_tick = t; inc = i; dec = d;
        if (r) begin
            m_cnt = 0; m_req = DI; m_act = DI; m_pwm = 0; m_ps = 0; m_incd = 0; m_decd = 0;
        end else begin
            ir = i && !m_incd;
            dr = d && !m_decd;
            nreq = m_req;
            if (ir && !dr) nreq = (m_req + S > P) ? P : m_req + S;
            else if (dr && !ir) nreq = (m_req < S) ? 0 : m_req - S;
            m_pwm = (m_cnt < m_act);
            if (t) begin
                if (m_cnt == P - 1) begin m_cnt = 0; m_act = m_req; m_ps = 1; end
                else begin m_cnt = m_cnt + 1; m_ps = 0; end
            end else begin
                m_ps = 0;
            end
            m_req = nreq; m_incd = i; m_decd = d;
        end
        sb_q.push_back('{pwm: m_pwm, duty: 8'(m_req), ps: m_ps});
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
    endtask

    task automatic do_reset();
        exp_t e;
        drive_cycle(1, 0, 0, 0, e);
        drive_cycle(1, 0, 0, 0, e);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1, 1, k[0], 0, e);
            total++;
            if ({pwm_out, duty, period_start} !== {1'b0, 8'd50, 1'b0}) begin
                bad++;
                $display("FAIL reset_state got pwm=%b duty=%0d ps=%b want 0 50 0", pwm_out, duty, period_start);
            end
        end
    endtask

    task automatic test_default_wave();
        exp_t e;
        int hi = 0, first_ps = -1, nps = 0;
        do_reset();
        for (int k = 1; k <= 200; k++) begin
            drive_cycle(0, 1, 0, 0, e);
            total++;
            if ({pwm_out, duty, period_start} !== e) begin
                bad++;
                $display("FAIL default_sb k=%0d got %b/%0d/%b want %b/%0d/%b", k, pwm_out, duty, period_start, e.pwm, e.duty, e.ps);
            end
            if (k <= 100 && pwm_out) hi++;
            if (period_start) begin nps++; if (first_ps < 0) first_ps = k; end
        end
        total++;
        if (hi !== 50) begin bad++; $display("FAIL default_high got %0d want 50", hi); end
        total++;
        if (first_ps !== 100) begin bad++; $display("FAIL default_first_ps got %0d want 100", first_ps); end
        total++;
        if (nps !== 2) begin bad++; $display("FAIL default_ps_count got %0d want 2", nps); end
    endtask

    task automatic test_saturate(input bit up);
        exp_t e;
        int want[6];
        int hi = 0;
        bit found = 0;
        if (up) want = '{60, 70, 80, 90, 100, 100};
        else    want = '{40, 30, 20, 10, 0, 0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive_cycle(0, 1, up, !up, e);
            total++;
            if (duty !== 8'(want[k]) || e.duty !== 8'(want[k])) begin
                bad++;
                $display("FAIL sat_step up=%0d k=%0d got %0d want %0d", up, k, duty, want[k]);
            end
            drive_cycle(0, 1, 0, 0, e);
        end
        for (int k = 0; k < 200 && !found; k++) begin
            drive_cycle(0, 1, 0, 0, e);
            found = period_start;
        end
        total++;
        if (!found) begin bad++; $display("FAIL sat_boundary up=%0d got none want period_start", up); end
        for (int k = 0; k < 100; k++) begin
            drive_cycle(0, 1, 0, 0, e);
            total++;
            if ({pwm_out, duty, period_start} !== e) begin
                bad++;
                $display("FAIL sat_sb up=%0d k=%0d got %b/%0d/%b want %b/%0d/%b", up, k, pwm_out, duty, period_start, e.pwm, e.duty, e.ps);
            end
            if (pwm_out) hi++;
        end
        total++;
        if (hi !== (up ? 100 : 0)) begin bad++; $display("FAIL sat_high up=%0d got %0d want %0d", up, hi, up ? 100 : 0); end
    endtask

    task automatic test_mid_period();
        exp_t e;
        int hi[5] = '{0, 0, 0, 0, 0};
        int want[5] = '{50, 60, 60, 60, 70};
        do_reset();
        for (int k = 1; k <= 500; k++) begin
            drive_cycle(0, 1, (k == 21 || k == 300), 0, e);
            total++;
            if ({pwm_out, duty, period_start} !== e) begin
                bad++;
                $display("FAIL mid_sb k=%0d got %b/%0d/%b want %b/%0d/%b", k, pwm_out, duty, period_start, e.pwm, e.duty, e.ps);
            end
            if (pwm_out) hi[(k - 1) / 100]++;
            if (k == 21) begin
                total++;
                if (duty !== 8'd60) begin bad++; $display("FAIL mid_duty got %0d want 60", duty); end
            end
            if (k == 300) begin
                total++;
                if (period_start !== 1'b1 || duty !== 8'd70) begin
                    bad++;
                    $display("FAIL wrap_inc got ps=%b duty=%0d want 1 70", period_start, duty);
                end
            end
        end
        for (int p = 0; p < 5; p++) begin
            total++;
            if (hi[p] !== want[p]) begin bad++; $display("FAIL mid_high period=%0d got %0d want %0d", p, hi[p], want[p]); end
        end
    endtask

    task automatic test_edges();
        exp_t e;
        do_reset();
        drive_cycle(0, 1, 1, 1, e);
        total++;
        if (duty !== 8'd50) begin bad++; $display("FAIL both_rise got %0d want 50", duty); end
        drive_cycle(0, 1, 0, 0, e);
        for (int k = 0; k < 20; k++) drive_cycle(0, 1, 1, 0, e);
        total++;
        if (duty !== 8'd60 || e.duty !== 8'd60) begin bad++; $display("FAIL held_inc got %0d want 60", duty); end
        drive_cycle(1, 1, 1, 0, e);
        drive_cycle(1, 1, 1, 0, e);
        total++;
        if (duty !== 8'd50) begin bad++; $display("FAIL held_rst got %0d want 50", duty); end
        drive_cycle(0, 1, 1, 0, e);
        total++;
        if (duty !== 8'd60) begin bad++; $display("FAIL held_release got %0d want 60", duty); end
        for (int k = 0; k < 5; k++) drive_cycle(0, 1, 1, 0, e);
        total++;
        if ({pwm_out, duty, period_start} !== e || duty !== 8'd60) begin
            bad++;
            $display("FAIL held_after got %b/%0d/%b want %b/60/%b", pwm_out, duty, period_start, e.pwm, e.ps);
        end
        drive_cycle(0, 1, 0, 0, e);
    endtask

    task automatic test_slow_tick();
        exp_t e;
        int hi = 0, nps = 0, first_ps = -1;
        do_reset();
        for (int k = 1; k <= 400; k++) begin
            drive_cycle(0, ((k - 1) % 4) == 0, 0, 0, e);
            total++;
            if ({pwm_out, duty, period_start} !== e) begin
                bad++;
                $display("FAIL slow_sb k=%0d got %b/%0d/%b want %b/%0d/%b", k, pwm_out, duty, period_start, e.pwm, e.duty, e.ps);
            end
            if (pwm_out) hi++;
            if (period_start) nps++;
        end
        total++;
        if (hi !== 200) begin bad++; $display("FAIL slow_high got %0d want 200", hi); end
        total++;
        if (nps !== 1) begin bad++; $display("FAIL slow_ps got %0d want 1", nps); end
        do_reset();
        drive_cycle(0, 1, 1, 0, e);
        for (int k = 1; k < 37; k++) drive_cycle(0, 1, 0, 0, e);
        drive_cycle(1, 1, 0, 0, e);
        total++;
        if ({pwm_out, duty, period_start} !== {1'b0, 8'd50, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset got %b/%0d/%b want 0/50/0", pwm_out, duty, period_start);
        end
        for (int k = 1; k <= 120 && first_ps < 0; k++) begin
            drive_cycle(0, 1, 0, 0, e);
            if (k == 1) begin
                total++;
                if (pwm_out !== 1'b1) begin bad++; $display("FAIL post_reset_pwm got %b want 1", pwm_out); end
            end
            if (period_start) first_ps = k;
        end
        total++;
        if (first_ps !== 100) begin bad++; $display("FAIL post_reset_wrap got %0d want 100", first_ps); end
    endtask

    initial begin
        test_reset();
        test_default_wave();
        test_saturate(1);
        test_saturate(0);
        test_mid_period();
        test_edges();
        test_slow_tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
